// File: rtl/ram_writer_pkg.sv
// Shared definitions for the burst RAM writer: default geometry and FSM state encoding.
package ram_writer_pkg;

    localparam int unsigned DefAddrWidth = 12;
    localparam int unsigned DefDataWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/ram_sp.sv
// Single-write-port RAM with a registered read port; the array itself is never reset.
module ram_sp #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Only the output register is reset; a same-address write lands after this read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_writer.sv
// Burst writer: accepts a base address and word count, then streams valid/ready data into RAM.
module ram_writer
    import ram_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  xfer;
    logic                  last;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        in_ready = (state_q == StWrite);
        busy     = (state_q == StWrite) || (state_q == StDone);
        done     = (state_q == StDone);
        xfer     = in_valid && in_ready;
        last     = (cnt_q == (len_q - AddrOne));
        // A start outside IDLE is dropped for control but flagged one cycle later.
        err_d    = start && (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d  = base_addr;
                        len_d   = length;
                        cnt_d   = '0;
                        state_d = StWrite;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWrite: begin
                if (xfer) begin
                    addr_d = addr_q + AddrOne;
                    cnt_d  = cnt_q + AddrOne;
                    if (last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    ram_sp #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (xfer),
        .waddr(addr_q),
        .wdata(in_data),
        .raddr(read_addr),
        .rdata(read_data)
    );

endmodule
